// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - RV32I load/store funct3 encodings
//   - LSU state encoding
//   - Fault cause codes
//   - Legality and alignment helpers used when an access is first seen
package mem_stage_lsu_pkg;

    // Access width/sign encodings (RV32I funct3 for LOAD/STORE)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    // Stores only have B/H/W; loads additionally have the unsigned B/H forms.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        logic legal;
        if (is_store) begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        end
        return !legal;
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = lo[0];
            F3_W:        mis = (lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Lane steering for the load/store unit (purely combinational).
//   funct3    : access width/sign
//   addr_lo   : byte offset within the word
//   wdata     : store data (rs2)
//   rdata     : raw bus read word
//   be        : byte enables for the access
//   wdata_rep : store data replicated across the byte lanes
//   rdata_ext : selected load lane, sign- or zero-extended
// Illegal funct3 values give be=0 and rdata_ext=0.
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] lane;

    always_comb begin
        lane      = rdata >> {addr_lo, 3'b000};
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{lane[7]}}, lane[7:0]};
            end
            F3_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'h0, lane[7:0]};
            end
            F3_H: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{lane[15]}}, lane[15:0]};
            end
            F3_HU: begin
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'h0, lane[15:0]};
            end
            F3_W: begin
                be        = 4'b1111;
                rdata_ext = lane;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit between EX_MEM and MEM_WB.
// Turns MemReadM/MemWriteM into a req/ack data bus transaction, stalls the
// pipeline while it is outstanding, and returns aligned/extended load data.
//   CLK, RST_N              : clock, async active-low reset
//   MemReadM, MemWriteM     : load / store present in MEM
//   Funct3M, ALUResultM     : access width/sign and byte address
//   WriteDataM              : store data
//   RD                      : load result latched by MEM_WB
//   StallM                  : hold IF..MEM
//   FaultM, FaultCause      : one-cycle fault pulse and its cause
//   DmemReq/We/Addr/WData/Be: registered bus request, stable until ack
//   DmemRData, DmemAck      : bus response
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       RD,
    output logic              StallM,
    output logic              FaultM,
    output logic [1:0]        FaultCause,
    output logic              DmemReq,
    output logic              DmemWe,
    output logic [ADDR_W-1:0] DmemAddr,
    output logic [31:0]       DmemWData,
    output logic [3:0]        DmemBe,
    input  logic [31:0]       DmemRData,
    input  logic              DmemAck
);

    localparam int unsigned   CntW    = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic [31:0]       rd_q, rd_d;

    logic              access;
    logic              illegal;
    logic              misal;
    logic              stall_c;
    logic              fault_c;
    logic [1:0]        cause_c;
    logic [2:0]        al_f3;
    logic [1:0]        al_lo;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;

    assign access  = MemReadM | MemWriteM;
    assign illegal = f3_illegal(MemWriteM, Funct3M);
    assign misal   = addr_misaligned(Funct3M, ALUResultM[1:0]);

    // One aligner serves both directions: in IDLE it shapes the incoming
    // store/enables, afterwards it extracts the load lane from latched state.
    assign al_f3 = (state_q == ST_IDLE) ? Funct3M : f3_q;
    assign al_lo = (state_q == ST_IDLE) ? ALUResultM[1:0] : lo_q;

    lsu_align u_align (
        .funct3    (al_f3),
        .addr_lo   (al_lo),
        .wdata     (WriteDataM),
        .rdata     (DmemRData),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        rd_d    = rd_q;
        stall_c = 1'b0;
        fault_c = 1'b0;
        cause_c = CAUSE_NONE;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (illegal) begin
                        fault_c = 1'b1;
                        cause_c = CAUSE_ILLEGAL;
                        rd_d    = 32'h0;
                    end else if (misal) begin
                        fault_c = 1'b1;
                        cause_c = CAUSE_MISALIGN;
                        rd_d    = 32'h0;
                    end else begin
                        stall_c = 1'b1;
                        req_d   = 1'b1;
                        we_d    = MemWriteM;
                        addr_d  = {ALUResultM[ADDR_W-1:2], 2'b00};
                        be_d    = al_be;
                        wdata_d = al_wdata;
                        f3_d    = Funct3M;
                        lo_d    = ALUResultM[1:0];
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CntW'(1);
                // An ack on the final allowed cycle beats the timeout.
                if (DmemAck) begin
                    if (!we_q) begin
                        rd_d = al_rdata;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CntLast) begin
                    fault_c = 1'b1;
                    cause_c = CAUSE_TIMEOUT;
                    rd_d    = 32'h0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Pipeline advances on this edge; the instruction still on the
                // inputs is the one just finished and must not be re-issued.
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            lo_q    <= 2'b00;
            rd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            rd_q    <= rd_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted so a
    // pending access on the inputs cannot leak a stall or fault.
    assign StallM     = stall_c & RST_N;
    assign FaultM     = fault_c & RST_N;
    assign FaultCause = RST_N ? cause_c : CAUSE_NONE;
    assign RD         = rd_q;
    assign DmemReq    = req_q;
    assign DmemWe     = we_q;
    assign DmemAddr   = addr_q;
    assign DmemWData  = wdata_q;
    assign DmemBe     = be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: the stimulus process pushes hand-computed
// expectations; a monitor pops and compares as the DUT presents bus requests,
// faults and stall completions.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    localparam int unsigned TO = 16;

    logic        CLK;
    logic        RST_N;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] RD;
    logic        StallM;
    logic        FaultM;
    logic [1:0]  FaultCause;
    logic        DmemReq;
    logic        DmemWe;
    logic [31:0] DmemAddr;
    logic [31:0] DmemWData;
    logic [3:0]  DmemBe;
    logic [31:0] DmemRData;
    logic        DmemAck;

    mem_stage_lsu #(
        .TIMEOUT (TO),
        .ADDR_W  (32)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RD         (RD),
        .StallM     (StallM),
        .FaultM     (FaultM),
        .FaultCause (FaultCause),
        .DmemReq    (DmemReq),
        .DmemWe     (DmemWe),
        .DmemAddr   (DmemAddr),
        .DmemWData  (DmemWData),
        .DmemBe     (DmemBe),
        .DmemRData  (DmemRData),
        .DmemAck    (DmemAck)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [1:0] cause;
        logic       stall;
        logic       chk_rd;
    } flt_exp_t;

    typedef struct {
        logic [31:0] rd;
        int          stalls;
    } cmp_exp_t;

    bus_exp_t bus_q[$];
    flt_exp_t flt_q[$];
    cmp_exp_t cmp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
        bus_q.push_back(e);
    endtask

    task automatic push_flt(input logic [1:0] cause, input logic stall, input logic chk_rd);
        flt_exp_t e;
        e.cause = cause; e.stall = stall; e.chk_rd = chk_rd;
        flt_q.push_back(e);
    endtask

    task automatic push_cmp(input logic [31:0] rd, input int stalls);
        cmp_exp_t e;
        e.rd = rd; e.stalls = stalls;
        cmp_q.push_back(e);
    endtask

    task automatic clear_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    // Legal access; waits < 0 means the ack is never given.
    task automatic issue_bus(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int waits, input logic [31:0] rdata);
        @(posedge CLK); #1;
        drive(rd, wr, f3, addr, wd);
        @(posedge CLK); #1;
        if (waits >= 0) begin
            repeat (waits) begin
                @(posedge CLK); #1;
            end
            DmemAck   = 1'b1;
            DmemRData = rdata;
            @(posedge CLK); #1;
            DmemAck   = 1'b0;
            DmemRData = 32'h0;
        end else begin
            repeat (TO) begin
                @(posedge CLK); #1;
            end
        end
        @(posedge CLK); #1;
        clear_inputs();
    endtask

    task automatic issue_fault(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr);
        @(posedge CLK); #1;
        drive(rd, wr, f3, addr, 32'h5A5A5A5A);
        @(posedge CLK); #1;
        clear_inputs();
    endtask

    // Monitor
    initial begin
        int       stall_cnt;
        logic     req_prev;
        logic     rd_next;
        bus_exp_t cur;
        flt_exp_t fe;
        cmp_exp_t ce;
        stall_cnt = 0;
        req_prev  = 1'b0;
        rd_next   = 1'b0;
        cur.we = 1'b0; cur.addr = 32'h0; cur.be = 4'h0; cur.wdata = 32'h0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                stall_cnt = 0;
                req_prev  = 1'b0;
                rd_next   = 1'b0;
                continue;
            end
            if (rd_next) begin
                chk("fault_rd_zero", RD, 32'h0);
                rd_next = 1'b0;
            end
            if (DmemReq && !req_prev) begin
                if (bus_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bus_unexpected: got addr %h expected no request", DmemAddr);
                end else begin
                    cur = bus_q.pop_front();
                    chk("bus_we", {31'h0, DmemWe}, {31'h0, cur.we});
                    chk("bus_addr", DmemAddr, cur.addr);
                    chk("bus_be", {28'h0, DmemBe}, {28'h0, cur.be});
                    chk("bus_wdata", DmemWData, cur.wdata);
                end
            end else if (DmemReq) begin
                chk("bus_stable", {DmemWe, DmemBe, DmemAddr[26:0]},
                    {cur.we, cur.be, cur.addr[26:0]});
            end
            req_prev = DmemReq;
            if (FaultM) begin
                if (flt_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL fault_unexpected: got cause %b expected no fault", FaultCause);
                end else begin
                    fe = flt_q.pop_front();
                    chk("fault_cause", {30'h0, FaultCause}, {30'h0, fe.cause});
                    chk("fault_stall", {31'h0, StallM}, {31'h0, fe.stall});
                    rd_next = fe.chk_rd;
                end
            end
            if (StallM) begin
                stall_cnt++;
            end else if (stall_cnt > 0) begin
                if (cmp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got stall run %0d expected none", stall_cnt);
                end else begin
                    ce = cmp_q.pop_front();
                    chk("done_rd", RD, ce.rd);
                    chk("stall_cycles", 32'(stall_cnt), 32'(ce.stalls));
                    chk("done_req_low", {31'h0, DmemReq}, 32'h0);
                end
                stall_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        RST_N     = 1'b0;
        DmemAck   = 1'b0;
        DmemRData = 32'h0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1;
        drive(1'b1, 1'b0, F3_W, 32'h100, 32'h0);
        #1;
        chk("rst_stall", {31'h0, StallM}, 32'h0);
        chk("rst_req", {31'h0, DmemReq}, 32'h0);
        chk("rst_rd", RD, 32'h0);
        chk("rst_fault", {31'h0, FaultM}, 32'h0);
        clear_inputs();
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // Word load, immediate ack
        push_bus(1'b0, 32'h100, 4'b1111, 32'h0);
        push_cmp(32'hDEADBEEF, 2);
        issue_bus(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 0, 32'hDEADBEEF);

        // Byte loads from the top lane
        push_bus(1'b0, 32'h100, 4'b1000, 32'h0);
        push_cmp(32'hFFFFFF80, 5);
        issue_bus(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 3, 32'h80FFFFFF);
        push_bus(1'b0, 32'h100, 4'b1000, 32'h0);
        push_cmp(32'h00000080, 2);
        issue_bus(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 0, 32'h80FFFFFF);

        // Stores leave RD unchanged
        push_bus(1'b1, 32'h20, 4'b1100, 32'hABCDABCD);
        push_cmp(32'h00000080, 3);
        issue_bus(1'b0, 1'b1, F3_H, 32'h22, 32'h1234ABCD, 1, 32'h55555555);
        push_bus(1'b1, 32'h10, 4'b0010, 32'hA5A5A5A5);
        push_cmp(32'h00000080, 2);
        issue_bus(1'b0, 1'b1, F3_B, 32'h11, 32'h000000A5, 0, 32'h55555555);
        push_bus(1'b1, 32'h44, 4'b1111, 32'h01020304);
        push_cmp(32'h00000080, 4);
        issue_bus(1'b0, 1'b1, F3_W, 32'h44, 32'h01020304, 2, 32'h55555555);

        // Halfword loads
        push_bus(1'b0, 32'h200, 4'b1100, 32'h0);
        push_cmp(32'hFFFF8001, 2);
        issue_bus(1'b1, 1'b0, F3_H, 32'h202, 32'h0, 0, 32'h80017FFF);
        push_bus(1'b0, 32'h200, 4'b0011, 32'h0);
        push_cmp(32'h0000F00D, 3);
        issue_bus(1'b1, 1'b0, F3_HU, 32'h200, 32'h0, 1, 32'h1234F00D);

        // Faults in IDLE
        push_flt(CAUSE_MISALIGN, 1'b0, 1'b1);
        issue_fault(1'b1, 1'b0, F3_W, 32'h101);
        push_bus(1'b0, 32'h108, 4'b1111, 32'h0);
        push_cmp(32'h11223344, 2);
        issue_bus(1'b1, 1'b0, F3_W, 32'h108, 32'h0, 0, 32'h11223344);
        push_flt(CAUSE_ILLEGAL, 1'b0, 1'b1);
        issue_fault(1'b1, 1'b0, 3'b011, 32'h100);
        push_flt(CAUSE_ILLEGAL, 1'b0, 1'b1);
        issue_fault(1'b1, 1'b0, 3'b011, 32'h101);
        push_flt(CAUSE_ILLEGAL, 1'b0, 1'b1);
        issue_fault(1'b0, 1'b1, 3'b100, 32'h0);
        push_flt(CAUSE_MISALIGN, 1'b0, 1'b1);
        issue_fault(1'b0, 1'b1, F3_H, 32'h23);

        // Timeout, then ack on the last allowed cycle
        push_bus(1'b0, 32'h10C, 4'b1111, 32'h0);
        push_cmp(32'h0A0B0C0D, 2);
        issue_bus(1'b1, 1'b0, F3_W, 32'h10C, 32'h0, 0, 32'h0A0B0C0D);
        push_bus(1'b0, 32'h300, 4'b1111, 32'h0);
        push_flt(CAUSE_TIMEOUT, 1'b1, 1'b0);
        push_cmp(32'h0, 17);
        issue_bus(1'b1, 1'b0, F3_W, 32'h300, 32'h0, -1, 32'h0);
        push_bus(1'b0, 32'h304, 4'b1111, 32'h0);
        push_cmp(32'hCAFEF00D, 17);
        issue_bus(1'b1, 1'b0, F3_W, 32'h304, 32'h0, 15, 32'hCAFEF00D);

        // Reset in the middle of a request
        push_bus(1'b0, 32'h400, 4'b1111, 32'h0);
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, F3_W, 32'h400, 32'h0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        chk("midrst_req", {31'h0, DmemReq}, 32'h0);
        chk("midrst_stall", {31'h0, StallM}, 32'h0);
        chk("midrst_rd", RD, 32'h0);
        chk("midrst_bus", {DmemWe, DmemBe, DmemAddr[26:0]}, 32'h0);
        chk("midrst_wdata_fault", {DmemWData[29:0], FaultM, FaultCause[0]}, 32'h0);
        clear_inputs();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        push_bus(1'b0, 32'h104, 4'b1111, 32'h0);
        push_cmp(32'h0BADF00D, 3);
        issue_bus(1'b1, 1'b0, F3_W, 32'h104, 32'h0, 1, 32'h0BADF00D);

        repeat (3) @(posedge CLK);
        #1;
        chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
        chk("flt_q_drained", 32'(flt_q.size()), 32'h0);
        chk("cmp_q_drained", 32'(cmp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
